// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN is consumed by spi_slave.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  // {CPOL,CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins, run-time config and host TX/RX handshake of the SPI slave.
// The slave modport is the DUT side; master is the host/bus side.
interface spi_slave_if #(
  parameter int WordLen = 8
);
  logic               CPOL;
  logic               CPHA;
  logic               Endianess;
  logic               SCLK;
  logic               SS;
  logic               MOSI;
  logic               MISO;
  logic [WordLen-1:0] TxData;
  logic               TxLoad;
  logic               TxReady;
  logic [WordLen-1:0] RxData;
  logic               RxValid;
  logic               TxUnderrun;
  logic               Busy;

  modport slave (
    input  CPOL, CPHA, Endianess,
    input  SCLK, SS, MOSI,
    output MISO,
    input  TxData, TxLoad,
    output TxReady, RxData, RxValid,
    output TxUnderrun, Busy
  );

  modport master (
    output CPOL, CPHA, Endianess,
    output SCLK, SS, MOSI,
    input  MISO,
    output TxData, TxLoad,
    input  TxReady, RxData, RxValid,
    input  TxUnderrun, Busy
  );
endinterface

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall detect.
// Edge pulses appear SyncStages+1 clk after the input changes.
module spi_sync_edge #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SyncStages-1:0] r_sync;
  logic                  r_prev;
  logic                  r_rise;
  logic                  r_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], i_d};
      r_prev <= r_sync[SyncStages-1];
      r_rise <= r_sync[SyncStages-1] & ~r_prev;
      r_fall <= ~r_sync[SyncStages-1] & r_prev;
    end
  end

  assign o_level = r_sync[SyncStages-1];
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled SCLK/SS/MOSI, all CPOL/CPHA modes, run-time bit order.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO whenever Busy=0.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WordLen    = 8,
  parameter int SyncStages = 2
) (
  input logic      clk,
  input logic      reset,
  spi_slave_if.slave bus
);
  localparam int CntW = (WordLen > 2) ? $clog2(WordLen) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WordLen - 1);

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic               r_cpol;
  logic               r_cpha;
  logic               r_endian;
  logic               r_miso;
  logic               r_busy;
  logic               r_tx_ready;
  logic [WordLen-1:0] r_tx_hold;
  logic [WordLen-1:0] r_tx_sh;
  logic [WordLen-1:0] r_rx_sh;
  logic [WordLen-1:0] r_rx_data;
  logic               r_rx_done;
  logic               r_rx_valid;
  logic               r_underrun;
  logic               r_udr_pend;

  logic w_sclk_lvl_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  spi_sync_edge #(.SyncStages(SyncStages)) u_sclk (
    .clk    (clk),
    .reset  (reset),
    .i_d    (bus.SCLK),
    .o_level(w_sclk_lvl_unused),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.SyncStages(SyncStages)) u_ss (
    .clk    (clk),
    .reset  (reset),
    .i_d    (bus.SS),
    .o_level(w_ss),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_sync_edge #(.SyncStages(SyncStages)) u_mosi (
    .clk    (clk),
    .reset  (reset),
    .i_d    (bus.MOSI),
    .o_level(w_mosi),
    .o_rise (w_mosi_rise_unused),
    .o_fall (w_mosi_fall_unused)
  );

  logic               w_lead;
  logic               w_trail;
  logic               w_sample;
  logic               w_shift;
  logic               w_word_end;
  logic               w_start;
  logic [WordLen-1:0] w_tx_word;
  logic [WordLen-1:0] w_tx_word_sh;
  logic [WordLen-1:0] w_tx_next;
  logic               w_tx_first;
  logic               w_tx_bit;
  logic [WordLen-1:0] w_rx_next;

  always_comb begin
    w_lead     = r_cpol ? w_sclk_fall : w_sclk_rise;
    w_trail    = r_cpol ? w_sclk_rise : w_sclk_fall;
    w_sample   = r_cpha ? w_trail : w_lead;
    w_shift    = r_cpha ? w_lead : w_trail;
    w_word_end = (r_state == ACTIVE) && !w_ss_rise
                 && w_sample && (r_cnt == LastBit);
    w_start    = ((r_state == IDLE) && w_ss_fall) || w_word_end;
    w_tx_word  = r_tx_ready ? '0 : r_tx_hold;
    if (r_endian == LSB_FIRST) begin
      w_tx_word_sh = w_tx_word >> 1;
      w_tx_next    = r_tx_sh >> 1;
      w_tx_first   = w_tx_word[0];
      w_tx_bit     = r_tx_sh[0];
      w_rx_next    = {w_mosi, r_rx_sh[WordLen-1:1]};
    end else begin
      w_tx_word_sh = w_tx_word << 1;
      w_tx_next    = r_tx_sh << 1;
      w_tx_first   = w_tx_word[WordLen-1];
      w_tx_bit     = r_tx_sh[WordLen-1];
      w_rx_next    = {r_rx_sh[WordLen-2:0], w_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WAIT_IDLE;
      r_cnt      <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_endian   <= MSB_FIRST;
      r_miso     <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_hold  <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_udr_pend <= 1'b0;
    end else begin
      r_rx_valid <= r_rx_done;
      r_rx_done  <= 1'b0;
      r_underrun <= 1'b0;

      // a word start frees the holding register for a same-cycle load
      if (bus.TxLoad && (r_tx_ready || w_start)) begin
        r_tx_hold  <= bus.TxData;
        r_tx_ready <= 1'b0;
      end else if (w_start) begin
        r_tx_ready <= 1'b1;
      end

      unique case (r_state)
        WAIT_IDLE: begin
          if (w_ss) r_state <= IDLE;
        end
        IDLE: begin
          r_cpol     <= bus.CPOL;
          r_cpha     <= bus.CPHA;
          r_endian   <= bus.Endianess;
          r_udr_pend <= 1'b0;
          if (w_ss_fall) begin
            r_state    <= ACTIVE;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_underrun <= r_tx_ready;
            if (!r_cpha) begin
              r_miso  <= w_tx_first;
              r_tx_sh <= w_tx_word_sh;
            end else begin
              r_tx_sh <= w_tx_word;
            end
          end
        end
        ACTIVE: begin
          if (w_ss_rise) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_udr_pend <= 1'b0;
          end else if (w_sample) begin
            r_rx_sh <= w_rx_next;
            // an empty reload is only flagged once the next word really starts
            if (r_udr_pend) begin
              r_underrun <= 1'b1;
              r_udr_pend <= 1'b0;
            end
            if (r_cnt == LastBit) begin
              r_cnt      <= '0;
              r_rx_data  <= w_rx_next;
              r_rx_done  <= 1'b1;
              r_tx_sh    <= w_tx_word;
              r_udr_pend <= r_tx_ready;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_shift) begin
            r_miso  <= w_tx_bit;
            r_tx_sh <= w_tx_next;
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.MISO = r_busy ? r_miso : 1'bz;
`else
  assign bus.MISO = r_miso;
`endif
  assign bus.TxReady    = r_tx_ready;
  assign bus.RxData     = r_rx_data;
  assign bus.RxValid    = r_rx_valid;
  assign bus.TxUnderrun = r_underrun;
  assign bus.Busy       = r_busy;
endmodule
